driver_weights_sparse: RTL and testbench

Parametrised weight-lane driver with buffering and optional bitmask-sparse decompression. It accepts MEM_BW-bit words from weight SRAM over a valid/ready handshake and unpacks them into NUM_LANES = MEM_BW/IO_DATA_WIDTH lanes, with lane 0 taken from the MSBs. Each unpacked vector is held in an output register until the PE array accepts it. In sparse mode, each vector is rebuilt from a lane mask word plus one packed data word, with zeros inserted in masked-off lanes.

---
 rtl/driver_weights_sparse.sv | 101 ++++++++++
 tb/tb_driver_weights_sparse.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/driver_weights_sparse.sv
// Weight-lane driver: unpacks MEM_BW-bit SRAM words into lanes (lane 0 = MSBs),
// with optional bitmask-sparse decompression (mask word followed by packed data word).
module driver_weights_sparse #(
  parameter int IO_DATA_WIDTH = 8,
  parameter int MEM_BW        = 128,
  localparam int NUM_LANES    = MEM_BW / IO_DATA_WIDTH,
  localparam int ZW           = $clog2(NUM_LANES + 1)
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic [MEM_BW-1:0]        weights_input,
  input  logic                     weights_in_valid,
  output logic                     weights_in_ready,
  input  logic                     sparse_mode,
  output logic [IO_DATA_WIDTH-1:0] weights_output [0:NUM_LANES-1],
  output logic                     weights_out_valid,
  input  logic                     weights_out_ready,
  output logic [ZW-1:0]            zero_lanes
);

  // state     | meaning
  // FIRST     | expecting a dense word or a sparse mask word
  // WAIT_DATA | mask stored, expecting the packed data word
  typedef enum logic {FIRST = 1'b0, WAIT_DATA = 1'b1} state_t;

  localparam int SW = $clog2(NUM_LANES);

  state_t                   state;
  logic [NUM_LANES-1:0]     mask_q;
  logic [NUM_LANES-1:0]     mask_in;
  logic [IO_DATA_WIDTH-1:0] slots   [0:NUM_LANES-1];
  logic [IO_DATA_WIDTH-1:0] scatter [0:NUM_LANES-1];
  logic [ZW-1:0]            pop;
  logic [SW-1:0]            slot_idx;
  logic                     out_space;
  logic                     accept;
  logic                     load;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_slot
    assign slots[k]   = weights_input[MEM_BW-1-IO_DATA_WIDTH*k -: IO_DATA_WIDTH];
    assign mask_in[k] = weights_input[MEM_BW-1-k];
  end

  assign out_space = !weights_out_valid || weights_out_ready;

  // A non-zero mask never touches the output register, so it may enter while full.
  assign weights_in_ready = (state == FIRST && sparse_mode) ? ((|mask_in) || out_space)
                                                            : out_space;
  assign accept = weights_in_valid && weights_in_ready;
  assign load   = accept && !(state == FIRST && sparse_mode && (|mask_in));

  always_comb begin
    pop      = '0;
    slot_idx = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      scatter[i] = '0;
      if (mask_q[i]) begin
        scatter[i] = slots[slot_idx];
        slot_idx   = slot_idx + SW'(1);
        pop        = pop + ZW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state             <= FIRST;
      mask_q            <= '0;
      weights_out_valid <= 1'b0;
      zero_lanes        <= '0;
      for (int i = 0; i < NUM_LANES; i++) weights_output[i] <= '0;
    end else begin
      if (load) weights_out_valid <= 1'b1;
      else if (weights_out_valid && weights_out_ready) weights_out_valid <= 1'b0;

      if (accept) begin
        case (state)
          FIRST: begin
            if (!sparse_mode) begin
              for (int i = 0; i < NUM_LANES; i++) weights_output[i] <= slots[i];
              zero_lanes <= '0;
            end else if (mask_in == '0) begin
              for (int i = 0; i < NUM_LANES; i++) weights_output[i] <= '0;
              zero_lanes <= ZW'(NUM_LANES);
            end else begin
              mask_q <= mask_in;
              state  <= WAIT_DATA;
            end
          end
          WAIT_DATA: begin
            for (int i = 0; i < NUM_LANES; i++) weights_output[i] <= scatter[i];
            zero_lanes <= ZW'(NUM_LANES) - pop;
            state      <= FIRST;
          end
          default: state <= FIRST;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_driver_weights_sparse.sv
// Directed bench for driver_weights_sparse (default 8-bit lanes, 128-bit words).
module tb_driver_weights_sparse;

  localparam int L = 16;

  logic         clk = 1'b0;
  logic         arst_n_in;
  logic [127:0] weights_input;
  logic         weights_in_valid;
  logic         weights_in_ready;
  logic         sparse_mode;
  logic [7:0]   weights_output [0:L-1];
  logic         weights_out_valid;
  logic         weights_out_ready;
  logic [4:0]   zero_lanes;

  int checks = 0;
  int failures = 0;

  driver_weights_sparse dut (
    .clk               (clk),
    .arst_n_in         (arst_n_in),
    .weights_input     (weights_input),
    .weights_in_valid  (weights_in_valid),
    .weights_in_ready  (weights_in_ready),
    .sparse_mode       (sparse_mode),
    .weights_output    (weights_output),
    .weights_out_valid (weights_out_valid),
    .weights_out_ready (weights_out_ready),
    .zero_lanes        (zero_lanes)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] out_vec();
    logic [127:0] v;
    for (int k = 0; k < L; k++) v[127-8*k -: 8] = weights_output[k];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] W_DENSE = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] W2 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [127:0] W3 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] W4 = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
  localparam logic [127:0] W5 = 128'h55AA55AA_33CC33CC_0FF00FF0_A5A5A5A5;

  logic [127:0] mw [0:5];
  logic         ms [0:5];
  logic [127:0] ev [0:4];
  logic [4:0]   ez [0:4];

  initial begin
    int  idx;
    int  ei;
    logic fire, cons;

    arst_n_in = 1'b0;
    weights_input = '0;
    weights_in_valid = 1'b0;
    sparse_mode = 1'b0;
    weights_out_ready = 1'b0;
    #12;
    chk("rst_valid", weights_out_valid, 0);
    chk("rst_vec", out_vec(), 0);
    chk("rst_zl", zero_lanes, 0);
    chk("rst_ready", weights_in_ready, 1);
    @(negedge clk);
    arst_n_in = 1'b1;
    tick();

    // dense ordering
    weights_in_valid = 1'b1;
    weights_input = W_DENSE;
    #1 chk("dense_ready", weights_in_ready, 1);
    tick();
    chk("dense_valid", weights_out_valid, 1);
    chk("dense_lane0", weights_output[0], 8'h00);
    chk("dense_lane7", weights_output[7], 8'h77);
    chk("dense_lane15", weights_output[15], 8'hFF);
    chk("dense_vec", out_vec(), W_DENSE);
    chk("dense_zl", zero_lanes, 0);

    // backpressure
    weights_input = W2;
    #1 chk("bp_ready0", weights_in_ready, 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_vec", out_vec(), W_DENSE);
      chk("bp_valid", weights_out_valid, 1);
      chk("bp_ready", weights_in_ready, 0);
    end
    weights_in_valid = 1'b0;
    sparse_mode = 1'b1;
    weights_input = 128'h80000000_00000000_00000000_00000000;
    #1 chk("bp_sparse_nz_ready", weights_in_ready, 1);
    weights_input = 128'h0000FFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    #1 chk("bp_sparse_z_ready", weights_in_ready, 0);
    sparse_mode = 1'b0;

    weights_out_ready = 1'b1;
    weights_in_valid = 1'b1;
    weights_input = W2;
    tick(); chk("b2b_w2", out_vec(), W2);
    weights_input = W3;
    tick(); chk("b2b_w3", out_vec(), W3);
    weights_input = W4;
    tick(); chk("b2b_w4", out_vec(), W4);
    chk("b2b_valid", weights_out_valid, 1);
    weights_in_valid = 1'b0;
    tick(); chk("b2b_drain", weights_out_valid, 0);

    // sparse: lanes 0, 3, 15
    weights_in_valid = 1'b1;
    sparse_mode = 1'b1;
    weights_input = 128'h90010000_00000000_00000000_00000000;
    tick(); chk("sp_mask_noout", weights_out_valid, 0);
    sparse_mode = 1'b0;
    weights_input = 128'hA1B2C3FF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    tick();
    chk("sp_vec", out_vec(), 128'hA10000B2_00000000_00000000_000000C3);
    chk("sp_zl", zero_lanes, 13);
    chk("sp_valid", weights_out_valid, 1);

    // all-zero mask
    sparse_mode = 1'b1;
    weights_input = 128'h0000FFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    tick();
    chk("zm_vec", out_vec(), 0);
    chk("zm_zl", zero_lanes, 16);
    chk("zm_valid", weights_out_valid, 1);
    sparse_mode = 1'b0;
    weights_input = W_DENSE;
    tick();
    chk("zm_next_dense", out_vec(), W_DENSE);
    chk("zm_next_zl", zero_lanes, 0);

    // all-ones mask
    sparse_mode = 1'b1;
    weights_input = 128'hFFFF0000_00000000_00000000_00000000;
    tick(); chk("om_noout", weights_out_valid, 0);
    sparse_mode = 1'b1;
    weights_input = W_DENSE;
    tick();
    chk("om_vec", out_vec(), W_DENSE);
    chk("om_zl", zero_lanes, 0);

    // reset in WAIT_DATA
    weights_input = 128'h40000000_00000000_00000000_00000000;
    tick();
    weights_in_valid = 1'b0;
    arst_n_in = 1'b0;
    #2;
    chk("mrst_valid", weights_out_valid, 0);
    chk("mrst_vec", out_vec(), 0);
    chk("mrst_zl", zero_lanes, 0);
    @(negedge clk);
    arst_n_in = 1'b1;
    weights_in_valid = 1'b1;
    sparse_mode = 1'b0;
    weights_input = W5;
    tick();
    chk("mrst_dense", out_vec(), W5);
    chk("mrst_dense_zl", zero_lanes, 0);

    // mask accepted while full, data held off until space
    weights_out_ready = 1'b0;
    weights_in_valid = 1'b0;
    sparse_mode = 1'b1;
    weights_input = '0;
    #1 chk("full_zmask_ready", weights_in_ready, 0);
    weights_input = 128'h80000000_00000000_00000000_00000000;
    #1 chk("full_mask_ready", weights_in_ready, 1);
    weights_in_valid = 1'b1;
    tick();
    chk("full_mask_hold", out_vec(), W5);
    sparse_mode = 1'b0;
    weights_input = 128'hEE112233_44556677_8899AABB_CCDDEEFF;
    #1 chk("full_data_ready", weights_in_ready, 0);
    tick();
    chk("full_data_hold", out_vec(), W5);
    weights_out_ready = 1'b1;
    tick();
    chk("full_data_vec", out_vec(), 128'hEE000000_00000000_00000000_00000000);
    chk("full_data_zl", zero_lanes, 15);
    weights_in_valid = 1'b0;
    tick();

    // mixed stream with random output backpressure
    mw[0] = W3;                                        ms[0] = 1'b0;
    mw[1] = 128'h60000000_00000000_00000000_00000000;  ms[1] = 1'b1;
    mw[2] = 128'h11223344_55667788_99AABBCC_DDEEFF00;  ms[2] = 1'b1;
    mw[3] = W4;                                        ms[3] = 1'b0;
    mw[4] = 128'h00001234_56789ABC_DEF01234_56789ABC;  ms[4] = 1'b1;
    mw[5] = W2;                                        ms[5] = 1'b0;
    ev[0] = W3;                                        ez[0] = 0;
    ev[1] = 128'h00112200_00000000_00000000_00000000;  ez[1] = 14;
    ev[2] = W4;                                        ez[2] = 0;
    ev[3] = '0;                                        ez[3] = 16;
    ev[4] = W2;                                        ez[4] = 0;
    idx = 0;
    ei = 0;
    for (int cyc = 0; cyc < 300 && (idx < 6 || ei < 5); cyc++) begin
      weights_in_valid = (idx < 6);
      if (idx < 6) begin
        weights_input = mw[idx];
        sparse_mode = ms[idx];
      end
      weights_out_ready = 1'($urandom_range(0, 1));
      #1;
      fire = weights_in_valid && weights_in_ready;
      cons = weights_out_valid && weights_out_ready;
      if (cons) begin
        if (ei < 5) begin
          chk("mix_vec", out_vec(), ev[ei]);
          chk("mix_zl", zero_lanes, ez[ei]);
        end else begin
          chk("mix_extra", 1, 0);
        end
        ei++;
      end
      tick();
      if (fire) idx++;
    end
    chk("mix_sent", idx, 6);
    chk("mix_recv", ei, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
